// File: rtl/io_link_rx.sv
`default_nettype none
// ============================================================================
// Module      : io_link_rx
// Description : Word-serial link receiver. Synchronizes the link strobe/data,
//               captures one word per strobe transition into a show-ahead
//               FIFO and presents it over valid/ready.
//               Optional: IO_LINK_RX_ZERO_FILTER_EN drops all-zero idle words.
// Revision    : 1.0 - initial release
// ============================================================================
module io_link_rx #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             link_clk,
  input  logic [WIDTH-1:0] link_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int            ADDR_W     = $clog2(DEPTH);
  localparam logic [1:0]    c_arm_done = 2'd3;
  localparam logic [CW-1:0] c_full     = CW'(DEPTH);

  logic             c1_q, c2_q, c3_q;
  logic             c1_d, c2_d, c3_d;
  logic [WIDTH-1:0] d1_q, d2_q;
  logic [WIDTH-1:0] d1_d, d2_d;
  logic [1:0]       arm_q, arm_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic w_edge;
  logic w_cand;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // The arm counter masks the spurious transition seen when link_clk is
  // already high as the reset-cleared synchronizer fills up.
  always_comb begin
    w_edge = (c2_q ^ c3_q) && (arm_q == c_arm_done);
`ifdef IO_LINK_RX_ZERO_FILTER_EN
    w_cand = w_edge && (d2_q != '0);
`else
    w_cand = w_edge;
`endif
    w_pop  = (count_q != '0) && out_ready;
    w_push = w_cand && ((count_q != c_full) || w_pop);
    w_drop = w_cand && !w_push;
  end

  always_comb begin
    c1_d       = link_clk;
    c2_d       = c1_q;
    c3_d       = c2_q;
    d1_d       = link_data;
    d2_d       = d1_q;
    arm_d      = (arm_q == c_arm_done) ? arm_q : arm_q + 2'd1;
    wr_ptr_d   = w_push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = w_pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + CW'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - CW'(1);
    end
    overflow_d = overflow_q | w_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c1_q       <= 1'b0;
      c2_q       <= 1'b0;
      c3_q       <= 1'b0;
      d1_q       <= '0;
      d2_q       <= '0;
      arm_q      <= 2'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      c3_q       <= c3_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      arm_q      <= arm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      mem_q[wr_ptr_q] <= d2_q;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_io_link_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_link_rx
// Description : Self-checking bench for io_link_rx against a word-level
//               queue model (honours IO_LINK_RX_ZERO_FILTER_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_link_rx;

  localparam int WIDTH = 13;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             link_clk;
  logic [WIDTH-1:0] link_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             overflow;

  io_link_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .link_clk  (link_clk),
    .link_data (link_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    logic [WIDTH-1:0] w;
  } pend_t;

  int               checks = 0;
  int               errors = 0;
  int               edge_n = 0;
  pend_t            pend_q[$];
  logic [WIDTH-1:0] model_q[$];
  bit               model_ovf = 1'b0;
  bit               rand_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic compare_all();
    logic [WIDTH-1:0] exp_data;
    exp_data = (model_q.size() != 0) ? model_q[0] : '0;
    check_eq("count",     32'(count),     32'(model_q.size()));
    check_eq("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check_eq("out_data",  32'(out_data),  32'(exp_data));
    check_eq("overflow",  32'(overflow),  32'(model_ovf));
  endtask

  // One clk cycle: check at the negedge, then apply the word-level rules
  // for the coming rising edge.
  task automatic tick();
    bit               do_pop;
    bit               cand;
    bit               keep;
    logic [WIDTH-1:0] w;
    compare_all();
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    do_pop = out_ready && (model_q.size() != 0);
    cand   = 1'b0;
    w      = '0;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      model_q.delete();
      pend_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (pend_q.size() != 0 && pend_q[0].due == edge_n) begin
        cand = 1'b1;
        w    = pend_q[0].w;
        void'(pend_q.pop_front());
      end
      if (do_pop) void'(model_q.pop_front());
      if (cand) begin
        keep = 1'b1;
`ifdef IO_LINK_RX_ZERO_FILTER_EN
        keep = (w != '0);
`endif
        if (keep) begin
          if (model_q.size() < DEPTH) model_q.push_back(w);
          else model_ovf = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  // A strobe transition before edge E lands in the FIFO at edge E+2.
  task automatic send(input logic [WIDTH-1:0] w, input int gap, input bit pop_on_capture);
    link_clk  = ~link_clk;
    link_data = w;
    pend_q.push_back('{due: edge_n + 3, w: w});
    for (int i = 0; i < gap; i++) begin
      if (!rand_ready) out_ready = pop_on_capture && (i == 2);
      tick();
    end
    if (!rand_ready) out_ready = 1'b0;
  endtask

  task automatic do_reset(input bit hold_high);
    rst       = 1'b1;
    out_ready = 1'b0;
    tick();
    if (hold_high) link_clk = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    link_clk  = 1'b0;
    link_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset(1'b0);
    check_eq("reset_count",    32'(count),     32'd0);
    check_eq("reset_valid",    32'(out_valid), 32'd0);
    check_eq("reset_data",     32'(out_data),  32'd0);
    check_eq("reset_overflow", 32'(overflow),  32'd0);

    send(13'h0A5, 3, 1'b0);
    check_eq("single_valid", 32'(out_valid), 32'd1);
    check_eq("single_data",  32'(out_data),  32'h0A5);
    check_eq("single_count", 32'(count),     32'd1);
    drain(2);

    for (int i = 1; i <= 5; i++) send(WIDTH'(i), 3, 1'b0);
    check_eq("burst_count", 32'(count), 32'd5);
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check_eq("burst_order", 32'(out_data), 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check_eq("burst_empty_count", 32'(count),    32'd0);
    check_eq("burst_empty_data",  32'(out_data), 32'd0);

    for (int i = 0; i < 17; i++) send(WIDTH'(13'h100 + i), 3, 1'b0);
    check_eq("ovf_count", 32'(count),    32'd16);
    check_eq("ovf_flag",  32'(overflow), 32'd1);
    check_eq("ovf_head",  32'(out_data), 32'h100);
    do_reset(1'b0);
    check_eq("ovf_rst_count", 32'(count),     32'd0);
    check_eq("ovf_rst_valid", 32'(out_valid), 32'd0);
    check_eq("ovf_rst_data",  32'(out_data),  32'd0);
    check_eq("ovf_rst_flag",  32'(overflow),  32'd0);

    for (int i = 0; i < 16; i++) send(WIDTH'(13'h200 + i), 3, 1'b0);
    send(13'h210, 3, 1'b1);
    check_eq("fullpop_count", 32'(count),    32'd16);
    check_eq("fullpop_flag",  32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("fullpop_order", 32'(out_data), 32'(13'h201 + i));
      tick();
    end
    out_ready = 1'b0;
    check_eq("fullpop_empty", 32'(count), 32'd0);

    do_reset(1'b1);
    check_eq("hold_high_count", 32'(count), 32'd0);
    send(13'h055, 3, 1'b0);
    tick();
    check_eq("hold_high_push", 32'(count),    32'd1);
    check_eq("hold_high_data", 32'(out_data), 32'h055);
    drain(2);

    send(13'h000, 3, 1'b0);
    send(13'h123, 3, 1'b0);
    send(13'h000, 3, 1'b0);
`ifdef IO_LINK_RX_ZERO_FILTER_EN
    check_eq("zero_filter_count", 32'(count), 32'd1);
`else
    check_eq("zero_filter_count", 32'(count), 32'd3);
`endif
    drain(4);

    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) send(WIDTH'($urandom), $urandom_range(3, 5), 1'b0);
    rand_ready = 1'b0;
    drain(20);
    check_eq("random_drained", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
